// File: rtl/pampy_ctrl_if.sv
// Control bundle between the pamPy sequencer and its datapath blocks.
// The sequencer uses the master view and the datapath uses the slave view.
interface pampy_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  run;
  logic [DATA_WIDTH-1:0] INSTR_IN;
  logic                  COMP_IN;
  logic [1:0]            SEL_MUX_OP1;
  logic [1:0]            SEL_MUX_OP2;
  logic                  CTRL_REG_OP1;
  logic                  CTRL_REG_OP2;
  logic [3:0]            SEL_ULA;
  logic                  CTRL_REG_INSTR;
  logic                  CTRL_REG_ARG;
  logic                  CTRL_REG_PC;
  logic                  SEL_MUX_PC;
  logic [1:0]            SEL_MUX_STACK;
  logic                  CTRL_STACK;
  logic                  CTRL_REG_TOS;
  logic                  SEL_MUX_TOS;
  logic                  HALTED;
  logic [1:0]            ERR_CODE;
  logic [3:0]            STATE_OUT;
  logic [ADDR_WIDTH-1:0] DEPTH_OUT;

  modport master (
    input  run, INSTR_IN, COMP_IN,
    output SEL_MUX_OP1, SEL_MUX_OP2, CTRL_REG_OP1, CTRL_REG_OP2, SEL_ULA,
           CTRL_REG_INSTR, CTRL_REG_ARG, CTRL_REG_PC, SEL_MUX_PC,
           SEL_MUX_STACK, CTRL_STACK, CTRL_REG_TOS, SEL_MUX_TOS,
           HALTED, ERR_CODE, STATE_OUT, DEPTH_OUT
  );

  modport slave (
    output run, INSTR_IN, COMP_IN,
    input  SEL_MUX_OP1, SEL_MUX_OP2, CTRL_REG_OP1, CTRL_REG_OP2, SEL_ULA,
           CTRL_REG_INSTR, CTRL_REG_ARG, CTRL_REG_PC, SEL_MUX_PC,
           SEL_MUX_STACK, CTRL_STACK, CTRL_REG_TOS, SEL_MUX_TOS,
           HALTED, ERR_CODE, STATE_OUT, DEPTH_OUT
  );
endinterface

// File: rtl/pampy_control_fsm.sv
// Multi-cycle control sequencer for the pamPy stack processor: decodes the
// latched opcode into datapath strobes, tracks stack depth, halts on faults.
//
// state   | meaning
// IDLE    | one cycle after reset
// FETCH   | load instruction/argument when run is high
// DECODE  | latch opcode and branch
// POP_A   | pop first operand into OP1
// POP_B   | pop second operand into OP2
// ALU     | drive ALU function from opcode
// PUSH    | write constant or ALU result to stack
// COND    | branch on registered compare flag
// PC_INC  | PC <= PC + 1
// PC_LOAD | PC <= argument
// HALT    | sticky stop, only reset leaves
module pampy_control_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic         clk,
  input  logic         reset,
  pampy_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_POP_A   = 4'd3,
    S_POP_B   = 4'd4,
    S_ALU     = 4'd5,
    S_PUSH    = 4'd6,
    S_COND    = 4'd7,
    S_PC_INC  = 4'd8,
    S_PC_LOAD = 4'd9,
    S_HALT    = 4'd15
  } state_e;

  localparam logic [DATA_WIDTH-1:0] OP_LOAD_CONST = DATA_WIDTH'('h64);
  localparam logic [DATA_WIDTH-1:0] OP_ADD        = DATA_WIDTH'('h17);
  localparam logic [DATA_WIDTH-1:0] OP_SUB        = DATA_WIDTH'('h18);
  localparam logic [DATA_WIDTH-1:0] OP_MUL        = DATA_WIDTH'('h14);
  localparam logic [DATA_WIDTH-1:0] OP_CMP        = DATA_WIDTH'('h6B);
  localparam logic [DATA_WIDTH-1:0] OP_POP_TOP    = DATA_WIDTH'('h01);
  localparam logic [DATA_WIDTH-1:0] OP_PJIF       = DATA_WIDTH'('h72);
  localparam logic [DATA_WIDTH-1:0] OP_JUMP       = DATA_WIDTH'('h71);
  localparam logic [DATA_WIDTH-1:0] OP_NOP        = DATA_WIDTH'('h09);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_UNDER   = 2'd2;
  localparam logic [1:0] ERR_OVER    = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_MAX = '1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;
  logic [1:0]            err_q, err_d;
  logic [ADDR_WIDTH-1:0] depth_q, depth_d;

  function automatic logic [3:0] alu_code(input logic [DATA_WIDTH-1:0] op);
    case (op)
      OP_ADD:  return 4'd0;
      OP_SUB:  return 4'd1;
      OP_MUL:  return 4'd2;
      OP_CMP:  return 4'd3;
      OP_PJIF: return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      err_q   <= ERR_NONE;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      depth_q <= depth_d;
    end
  end

  always_comb begin
    depth_d = depth_q;
    case (state_q)
      S_POP_A, S_POP_B: depth_d = depth_q - DEPTH_ONE;
      S_PUSH:           depth_d = depth_q + DEPTH_ONE;
      default:          depth_d = depth_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.run) state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.INSTR_IN;
        case (bus.INSTR_IN)
          OP_LOAD_CONST:                                         state_d = S_PUSH;
          OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_POP_TOP, OP_PJIF:   state_d = S_POP_A;
          OP_JUMP:                                               state_d = S_PC_LOAD;
          OP_NOP:                                                state_d = S_PC_INC;
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_POP_A: begin
        if (op_q == OP_POP_TOP)   state_d = S_PC_INC;
        else if (op_q == OP_PJIF) state_d = S_ALU;
        else                      state_d = S_POP_B;
      end
      S_POP_B:   state_d = S_ALU;
      S_ALU:     state_d = (op_q == OP_PJIF) ? S_COND : S_PUSH;
      S_PUSH:    state_d = S_PC_INC;
      S_COND:    state_d = bus.COMP_IN ? S_PC_INC : S_PC_LOAD;
      S_PC_INC:  state_d = S_FETCH;
      S_PC_LOAD: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase

    // Stack faults redirect the transition itself, so the faulting state never issues strobes.
    if ((state_d == S_POP_A || state_d == S_POP_B) && depth_d == '0) begin
      state_d = S_HALT;
      err_d   = ERR_UNDER;
    end else if (state_d == S_PUSH && depth_d == DEPTH_MAX) begin
      state_d = S_HALT;
      err_d   = ERR_OVER;
    end
  end

  always_comb begin
    bus.SEL_MUX_OP1    = 2'd0;
    bus.SEL_MUX_OP2    = 2'd0;
    bus.CTRL_REG_OP1   = 1'b0;
    bus.CTRL_REG_OP2   = 1'b0;
    bus.SEL_ULA        = 4'd0;
    bus.CTRL_REG_INSTR = 1'b0;
    bus.CTRL_REG_ARG   = 1'b0;
    bus.CTRL_REG_PC    = 1'b0;
    bus.SEL_MUX_PC     = 1'b0;
    bus.SEL_MUX_STACK  = 2'd0;
    bus.CTRL_STACK     = 1'b0;
    bus.CTRL_REG_TOS   = 1'b0;
    bus.SEL_MUX_TOS    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.CTRL_REG_INSTR = bus.run;
        bus.CTRL_REG_ARG   = bus.run;
      end
      S_POP_A: begin
        bus.CTRL_REG_OP1 = 1'b1;
        bus.CTRL_REG_TOS = 1'b1;
        bus.SEL_MUX_TOS  = 1'b1;
      end
      S_POP_B: begin
        bus.CTRL_REG_OP2 = 1'b1;
        bus.SEL_MUX_OP2  = 2'd1;
        bus.CTRL_REG_TOS = 1'b1;
        bus.SEL_MUX_TOS  = 1'b1;
      end
      S_ALU: bus.SEL_ULA = alu_code(op_q);
      S_PUSH: begin
        bus.CTRL_STACK    = 1'b1;
        bus.CTRL_REG_TOS  = 1'b1;
        bus.SEL_MUX_STACK = (op_q == OP_LOAD_CONST) ? 2'd0 : 2'd3;
        bus.SEL_ULA       = alu_code(op_q);
      end
      S_PC_INC: begin
        bus.SEL_MUX_OP2 = 2'd2;
        bus.SEL_ULA     = 4'd5;
        bus.CTRL_REG_PC = 1'b1;
      end
      S_PC_LOAD: begin
        bus.SEL_MUX_OP2 = 2'd0;
        bus.SEL_ULA     = 4'd4;
        bus.CTRL_REG_PC = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.HALTED    = (state_q == S_HALT);
  assign bus.ERR_CODE  = err_q;
  assign bus.STATE_OUT = state_q;
  assign bus.DEPTH_OUT = depth_q;

endmodule

// File: tb/tb_pampy_control_fsm.sv
// Directed bench for pampy_control_fsm: stimulus queues per-cycle expected
// snapshots, a negedge monitor compares them against two DUT instances.
module tb_pampy_control_fsm;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                         ST_POP_A = 4'd3, ST_POP_B = 4'd4, ST_ALU = 4'd5,
                         ST_PUSH = 4'd6, ST_COND = 4'd7, ST_PC_INC = 4'd8,
                         ST_PC_LOAD = 4'd9, ST_HALT = 4'd15;

  // Strobe word: op1[2] op2[2] rop1 rop2 ula[4] instr arg pc mux_pc stk_sel[2] stk tos mux_tos
  localparam logic [18:0] SB_NONE   = '0;
  localparam logic [18:0] SB_FETCH  = {2'd0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
  localparam logic [18:0] SB_POPA   = {2'd0, 2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
  localparam logic [18:0] SB_POPB   = {2'd0, 2'd1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
  localparam logic [18:0] SB_PUSHK  = {2'd0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
  localparam logic [18:0] SB_PUSHA  = {2'd0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
  localparam logic [18:0] SB_PCINC  = {2'd0, 2'd2, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
  localparam logic [18:0] SB_PCLOAD = {2'd0, 2'd0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
  localparam logic [18:0] M_ALL     = '1;
  localparam logic [18:0] M_NO_ULA  = ~19'h01E00;

  typedef struct {
    int          cyc;
    int          dut;
    string       tag;
    logic [3:0]  st;
    logic [11:0] dep;
    logic [1:0]  err;
    logic        halt;
    logic [18:0] sb;
    logic [18:0] msk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_a, reset_b;
  logic       run_s;
  logic [7:0] instr_s;
  logic       comp_s;
  int         cyc = 0;
  int         cur_dut = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       sbq[$];

  pampy_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) ifa ();
  pampy_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2))  ifb ();

  pampy_control_fsm #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) dut_a (
    .clk(clk), .reset(reset_a), .bus(ifa.master)
  );
  pampy_control_fsm #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset_b), .bus(ifb.master)
  );

  assign ifa.run = run_s;  assign ifa.INSTR_IN = instr_s;  assign ifa.COMP_IN = comp_s;
  assign ifb.run = run_s;  assign ifb.INSTR_IN = instr_s;  assign ifb.COMP_IN = comp_s;

  logic [18:0] sb_a, sb_b;
  assign sb_a = {ifa.SEL_MUX_OP1, ifa.SEL_MUX_OP2, ifa.CTRL_REG_OP1, ifa.CTRL_REG_OP2, ifa.SEL_ULA,
                 ifa.CTRL_REG_INSTR, ifa.CTRL_REG_ARG, ifa.CTRL_REG_PC, ifa.SEL_MUX_PC,
                 ifa.SEL_MUX_STACK, ifa.CTRL_STACK, ifa.CTRL_REG_TOS, ifa.SEL_MUX_TOS};
  assign sb_b = {ifb.SEL_MUX_OP1, ifb.SEL_MUX_OP2, ifb.CTRL_REG_OP1, ifb.CTRL_REG_OP2, ifb.SEL_ULA,
                 ifb.CTRL_REG_INSTR, ifb.CTRL_REG_ARG, ifb.CTRL_REG_PC, ifb.SEL_MUX_PC,
                 ifb.SEL_MUX_STACK, ifb.CTRL_STACK, ifb.CTRL_REG_TOS, ifb.SEL_MUX_TOS};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [3:0]  a_st;
    logic [11:0] a_dep;
    logic [1:0]  a_err;
    logic        a_halt;
    logic [18:0] a_sb;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: snapshot for cycle %0d not sampled (now %0d)", e.tag, e.cyc, cyc);
      end else begin
        if (e.dut == 0) begin
          a_st = ifa.STATE_OUT; a_dep = ifa.DEPTH_OUT; a_err = ifa.ERR_CODE;
          a_halt = ifa.HALTED; a_sb = sb_a;
        end else begin
          a_st = ifb.STATE_OUT; a_dep = {10'd0, ifb.DEPTH_OUT}; a_err = ifb.ERR_CODE;
          a_halt = ifb.HALTED; a_sb = sb_b;
        end
        if (a_st !== e.st || a_dep !== e.dep || a_err !== e.err || a_halt !== e.halt ||
            ((a_sb ^ e.sb) & e.msk) !== 19'd0) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got st=%0d dep=%0d err=%0d halt=%0b sb=%05h, want st=%0d dep=%0d err=%0d halt=%0b sb=%05h (mask %05h)",
                   e.tag, cyc, a_st, a_dep, a_err, a_halt, a_sb, e.st, e.dep, e.err, e.halt, e.sb, e.msk);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ex(input int k, input string t, input logic [3:0] st, input int dep,
                    input logic [1:0] err, input logic [18:0] sb, input logic [18:0] msk);
    exp_t e;
    e.cyc = cyc + k;  e.dut = cur_dut;  e.tag = t;  e.st = st;
    e.dep = 12'(dep); e.err = err;      e.halt = (st == ST_HALT);
    e.sb  = sb;       e.msk = msk;
    sbq.push_back(e);
  endtask

  // All instruction tasks start with the FSM sitting in FETCH in the current cycle.
  task automatic lc(input string t, input int d);
    instr_s = 8'h64;
    ex(0, {t, ".fetch"},  ST_FETCH,  d,     2'd0, SB_FETCH, M_ALL);
    ex(1, {t, ".decode"}, ST_DECODE, d,     2'd0, SB_NONE,  M_ALL);
    ex(2, {t, ".push"},   ST_PUSH,   d,     2'd0, SB_PUSHK, M_NO_ULA);
    ex(3, {t, ".pcinc"},  ST_PC_INC, d + 1, 2'd0, SB_PCINC, M_ALL);
    tick(4);
  endtask

  task automatic binop(input string t, input logic [7:0] op, input logic [3:0] ula, input int d);
    instr_s = op;
    ex(0, {t, ".fetch"},  ST_FETCH,  d,     2'd0, SB_FETCH, M_ALL);
    ex(1, {t, ".decode"}, ST_DECODE, d,     2'd0, SB_NONE,  M_ALL);
    ex(2, {t, ".pop_a"},  ST_POP_A,  d,     2'd0, SB_POPA,  M_ALL);
    ex(3, {t, ".pop_b"},  ST_POP_B,  d - 1, 2'd0, SB_POPB,  M_ALL);
    ex(4, {t, ".alu"},    ST_ALU,    d - 2, 2'd0, {6'd0, ula, 9'd0}, M_ALL);
    ex(5, {t, ".push"},   ST_PUSH,   d - 2, 2'd0, SB_PUSHA | {6'd0, ula, 9'd0}, M_ALL);
    ex(6, {t, ".pcinc"},  ST_PC_INC, d - 1, 2'd0, SB_PCINC, M_ALL);
    tick(7);
  endtask

  task automatic pjif(input string t, input logic comp, input int d);
    instr_s = 8'h72;
    comp_s  = comp;
    ex(0, {t, ".fetch"},  ST_FETCH,  d,     2'd0, SB_FETCH, M_ALL);
    ex(1, {t, ".decode"}, ST_DECODE, d,     2'd0, SB_NONE,  M_ALL);
    ex(2, {t, ".pop_a"},  ST_POP_A,  d,     2'd0, SB_POPA,  M_ALL);
    ex(3, {t, ".alu"},    ST_ALU,    d - 1, 2'd0, {6'd0, 4'd6, 9'd0}, M_ALL);
    ex(4, {t, ".cond"},   ST_COND,   d - 1, 2'd0, SB_NONE,  M_ALL);
    if (comp) ex(5, {t, ".pcinc"},  ST_PC_INC,  d - 1, 2'd0, SB_PCINC,  M_ALL);
    else      ex(5, {t, ".pcload"}, ST_PC_LOAD, d - 1, 2'd0, SB_PCLOAD, M_ALL);
    tick(6);
  endtask

  initial begin
    reset_a = 1'b1;  reset_b = 1'b1;
    run_s   = 1'b1;  instr_s = 8'h64;  comp_s = 1'b0;
    tick(1);

    cur_dut = 0;
    ex(0, "a.reset", ST_IDLE, 0, 2'd0, SB_NONE, M_ALL);
    reset_a = 1'b0;
    tick(1);
    lc("lc0", 0);
    lc("lc1", 1);
    binop("add", 8'h17, 4'd0, 2);
    lc("lc2", 1);
    binop("sub", 8'h18, 4'd1, 2);
    lc("lc3", 1);
    binop("mul", 8'h14, 4'd2, 2);
    lc("lc4", 1);
    binop("cmp", 8'h6B, 4'd3, 2);
    pjif("pjif0", 1'b0, 1);
    lc("lc5", 0);
    pjif("pjif1", 1'b1, 1);

    instr_s = 8'h71;
    ex(0, "jump.fetch",  ST_FETCH,   0, 2'd0, SB_FETCH,  M_ALL);
    ex(1, "jump.decode", ST_DECODE,  0, 2'd0, SB_NONE,   M_ALL);
    ex(2, "jump.pcload", ST_PC_LOAD, 0, 2'd0, SB_PCLOAD, M_ALL);
    tick(3);

    // run drops mid-NOP: the instruction completes, then FETCH idles quietly.
    instr_s = 8'h09;
    ex(0, "nop.fetch",  ST_FETCH,  0, 2'd0, SB_FETCH, M_ALL);
    ex(1, "nop.decode", ST_DECODE, 0, 2'd0, SB_NONE,  M_ALL);
    ex(2, "nop.pcinc",  ST_PC_INC, 0, 2'd0, SB_PCINC, M_ALL);
    ex(3, "idle.f0",    ST_FETCH,  0, 2'd0, SB_NONE,  M_ALL);
    ex(4, "idle.f1",    ST_FETCH,  0, 2'd0, SB_NONE,  M_ALL);
    tick(1);
    run_s = 1'b0;
    tick(4);
    run_s = 1'b1;

    lc("lc6", 0);
    instr_s = 8'h01;
    ex(0, "popt.fetch",  ST_FETCH,  1, 2'd0, SB_FETCH, M_ALL);
    ex(1, "popt.decode", ST_DECODE, 1, 2'd0, SB_NONE,  M_ALL);
    ex(2, "popt.pop_a",  ST_POP_A,  1, 2'd0, SB_POPA,  M_ALL);
    ex(3, "popt.pcinc",  ST_PC_INC, 0, 2'd0, SB_PCINC, M_ALL);
    tick(4);

    ex(0, "under.fetch",  ST_FETCH,  0, 2'd0, SB_FETCH, M_ALL);
    ex(1, "under.decode", ST_DECODE, 0, 2'd0, SB_NONE,  M_ALL);
    for (int i = 2; i < 22; i++) ex(i, "under.halt", ST_HALT, 0, 2'd2, SB_NONE, M_ALL);
    tick(5);
    instr_s = 8'h64;
    tick(17);

    reset_a = 1'b1;
    tick(1);
    ex(0, "a.reset2", ST_IDLE, 0, 2'd0, SB_NONE, M_ALL);
    reset_a = 1'b0;
    tick(1);

    instr_s = 8'hFF;
    ex(0, "ill.fetch",  ST_FETCH,  0, 2'd0, SB_FETCH, M_ALL);
    ex(1, "ill.decode", ST_DECODE, 0, 2'd0, SB_NONE,  M_ALL);
    ex(2, "ill.halt0",  ST_HALT,   0, 2'd1, SB_NONE,  M_ALL);
    ex(3, "ill.halt1",  ST_HALT,   0, 2'd1, SB_NONE,  M_ALL);
    tick(4);
    reset_a = 1'b1;
    tick(1);
    ex(0, "a.reset3", ST_IDLE, 0, 2'd0, SB_NONE, M_ALL);

    cur_dut = 1;
    ex(0, "b.reset", ST_IDLE, 0, 2'd0, SB_NONE, M_ALL);
    reset_b = 1'b0;
    tick(1);
    lc("b.lc0", 0);
    lc("b.lc1", 1);
    lc("b.lc2", 2);
    instr_s = 8'h64;
    ex(0, "over.fetch",  ST_FETCH,  3, 2'd0, SB_FETCH, M_ALL);
    ex(1, "over.decode", ST_DECODE, 3, 2'd0, SB_NONE,  M_ALL);
    ex(2, "over.halt0",  ST_HALT,   3, 2'd3, SB_NONE,  M_ALL);
    ex(3, "over.halt1",  ST_HALT,   3, 2'd3, SB_NONE,  M_ALL);
    tick(4);

    for (int i = 0; i < 40 && sbq.size() > 0; i++) @(posedge clk);
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: snapshot for cycle %0d still pending at cycle %0d", e.tag, e.cyc, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pampy_control_fsm.md
# pampy_control_fsm

Multi-cycle control sequencer for the pamPy stack processor. It consumes the opcode held in the instruction register and the registered ALU compare flag, and drives every datapath strobe and mux select of the ALU, PC/instruction, and stack/TOS blocks. It sits directly downstream of the instruction register and upstream of all datapath control inputs. It also tracks stack depth and halts on illegal opcodes or stack faults.

## Interface
- DATA_WIDTH, 8, opcode/argument width
- ADDR_WIDTH, 12, stack address width; the depth counter holds 0..2^ADDR_WIDTH−1
- clk  in  1  single system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  when low, the FSM holds in FETCH without asserting strobes
- INSTR_IN  in  DATA_WIDTH  opcode from the instruction register
- COMP_IN  in  1  registered ALU compare flag
- SEL_MUX_OP1, SEL_MUX_OP2  out  2  ALU operand selects (OP2: 0 = arg, 1 = TOS, 2 = PC)
- CTRL_REG_OP1, CTRL_REG_OP2  out  1  operand register loads
- SEL_ULA  out  4  0 ADD, 1 SUB, 2 MUL, 3 CMP_LT, 4 PASS_OP2, 5 INC_OP2, 6 TEST_ZERO
- CTRL_REG_INSTR, CTRL_REG_ARG  out  1  instruction/argument register loads
- CTRL_REG_PC, SEL_MUX_PC  out  1  PC load; SEL_MUX_PC = 0 selects ALU output
- SEL_MUX_STACK  out  2  stack write source (0 = arg, 3 = ALU)
- CTRL_STACK  out  1  stack write enable
- CTRL_REG_TOS, SEL_MUX_TOS  out  1  TOS update; SEL_MUX_TOS 0 = increment, 1 = decrement
- HALTED  out  1  sticky halt
- ERR_CODE  out  2  0 none, 1 illegal opcode, 2 underflow, 3 overflow
- STATE_OUT  out  4  current state encoding, for debug
- DEPTH_OUT  out  ADDR_WIDTH  current stack depth

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, POP_A 3, POP_B 4, ALU 5, PUSH 6, COND 7, PC_INC 8, PC_LOAD 9, HALT 15.
- All outputs are Moore, decoded from state (plus latched opcode). Any strobe not listed for a state is 0.
- IDLE: entered on reset, lasts 1 cycle, goes to FETCH.
- FETCH:
  - If run = 1, assert CTRL_REG_INSTR and CTRL_REG_ARG, then go to DECODE.
  - If run = 0, stay in FETCH with no strobes.
- DECODE: latch INSTR_IN into an internal opcode register, then branch:
  - 0x64 LOAD_CONST → PUSH with SEL_MUX_STACK = 0
  - 0x17 ADD, 0x18 SUB, 0x14 MUL, 0x6B COMPARE_OP → POP_A
  - 0x01 POP_TOP → POP_A
  - 0x72 POP_JUMP_IF_FALSE → POP_A
  - 0x71 JUMP_ABSOLUTE → PC_LOAD
  - 0x09 NOP → PC_INC
  - any other value → HALT with ERR_CODE = 1
- POP_A: CTRL_REG_OP1 = 1, CTRL_REG_TOS = 1, SEL_MUX_TOS = 1, depth −1. Next state:
  - POP_TOP → PC_INC
  - POP_JUMP_IF_FALSE → ALU
  - otherwise → POP_B
- POP_B: CTRL_REG_OP2 = 1, SEL_MUX_OP2 = 1, TOS decrement, depth −1, then ALU.
- ALU: drive SEL_ULA from the opcode (ADD 0, SUB 1, MUL 2, COMPARE_OP 3, POP_JUMP_IF_FALSE 6). Next state is COND for POP_JUMP_IF_FALSE, otherwise PUSH.
- PUSH:
  - CTRL_STACK = 1 and TOS increment (CTRL_REG_TOS = 1, SEL_MUX_TOS = 0), depth +1.
  - SEL_MUX_STACK = 0 for LOAD_CONST, 3 otherwise; SEL_ULA is held from the ALU state.
  - Next state PC_INC.
- COND: if COIN_IN = 0 go to PC_LOAD, else go to PC_INC. No strobes.
- PC_INC: SEL_MUX_OP2 = 2, SEL_ULA = 5, SEL_MUX_PC = 0, CTRL_REG_PC = 1, then FETCH.
- PC_LOAD: SEL_MUX_OP2 = 0, SEL_ULA = 4, SEL_MUX_PC = 0, CTRL_REG_PC = 1, then FETCH.
- HALT: absorbing state with all strobes 0 and HALTED = 1. Only reset leaves it.
- Depth counter is updated only in POP_A, POP_B and PUSH; it never wraps.

## Timing
- Reset: state = IDLE, every control output = 0, HALTED = 0, ERR_CODE = 0, DEPTH_OUT = 0. Reset asserted in any state, including HALT or mid-instruction, takes effect on the next edge with no partial strobes afterwards.
- Cycles per instruction, counted from FETCH through the state before the next FETCH:
  - JUMP_ABSOLUTE: 3
  - NOP: 3
  - LOAD_CONST: 4
  - POP_TOP: 4
  - POP_JUMP_IF_FALSE: 6
  - binary ops: 7
- Underflow: entering POP_A or POP_B with depth = 0 goes to HALT instead, with ERR_CODE = 2, no strobes, and depth unchanged.
- Overflow: entering PUSH with depth = 2^ADDR_WIDTH−1 goes to HALT instead, with ERR_CODE = 3 and no write.
- Fault checks are evaluated on the transition, so the faulting state's strobes never assert.
- run deasserting mid-instruction has no effect until the FSM returns to FETCH.
- COND samples COMP_IN exactly 1 cycle after ALU, allowing for the flag register.

## Test plan
- Reset, run = 1, INSTR_IN = 0x64: STATE_OUT sequence 0, 1, 2, 6, 8, 1; CTRL_STACK high only in cycle 4; DEPTH_OUT = 1.
- Two LOAD_CONST then 0x17: POP_A, POP_B, ALU (SEL_ULA = 0), PUSH (SEL_MUX_STACK = 3); final DEPTH_OUT = 1; the ADD takes 7 cycles.
- 0x72 at depth 1 with COMP_IN = 0: goes to PC_LOAD with SEL_ULA = 4. Repeated with COMP_IN = 1: goes to PC_INC. DEPTH_OUT = 0 in both cases.
- 0x01 at depth 0: HALT, ERR_CODE = 2, CTRL_REG_OP1 never asserted, and the FSM stays halted for 20 cycles.
- INSTR_IN = 0xFF: HALT with ERR_CODE = 1. Asserting reset for 1 cycle gives STATE_OUT = 0 and all outputs 0.
- ADDR_WIDTH = 2, four LOAD_CONST: the fourth goes to HALT with ERR_CODE = 3 and DEPTH_OUT = 3. Holding run = 0 in FETCH keeps STATE_OUT = 1 with no strobes.
